// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with iterative mul/divu/remu; optional shifts under SEQ_ALU_SHIFT_EN
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflowo,
    output logic             carryo,
    output logic             erro
);
    localparam int M = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [3:0]         op;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH:0]     sum, diff;
    logic               ovf_add, ovf_sub;
    logic [WIDTH-1:0]   s_out;
    logic               s_ovf, s_car, s_err, is_iter;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign ovf_add = (a[M] == b[M]) && (sum[M] != a[M]);
    assign ovf_sub = (a[M] != b[M]) && (diff[M] != a[M]);

`ifdef SEQ_ALU_SHIFT_EN
    // One spare bit on the shifted-out side captures the last bit lost.
    logic [WIDTH:0] shl_w, shr_w, sar_w;
    assign shl_w = {1'b0, a} << b[CW-1:0];
    assign shr_w = {a, 1'b0} >> b[CW-1:0];
    assign sar_w = $signed({a, 1'b0}) >>> b[CW-1:0];
`endif

    always_comb begin
        s_out   = '0;
        s_ovf   = 1'b0;
        s_car   = 1'b0;
        s_err   = 1'b0;
        is_iter = 1'b0;
        case (func)
            4'b0000: begin s_out = sum[M:0];  s_car = sum[WIDTH];  s_ovf = ovf_add; end
            4'b0001: begin s_out = diff[M:0]; s_car = diff[WIDTH]; s_ovf = ovf_sub; end
            4'b0010: s_out = ~a;
            4'b0011: s_out = a & b;
            4'b0100: s_out = a | b;
            4'b0101: s_out = a ^ b;
            4'b0110: s_out = {{(WIDTH-1){1'b0}}, diff[M] ^ ovf_sub};
            4'b0111: s_out = {{(WIDTH-1){1'b0}}, a == b};
            4'b1000, 4'b1001, 4'b1010: is_iter = 1'b1;
`ifdef SEQ_ALU_SHIFT_EN
            4'b1011: begin s_out = shl_w[M:0];     s_car = shl_w[WIDTH]; end
            4'b1100: begin s_out = shr_w[WIDTH:1]; s_car = shr_w[0];     end
            4'b1101: begin s_out = sar_w[WIDTH:1]; s_car = sar_w[0];     end
`endif
            default: s_err = 1'b1;
        endcase
    end

    // acc holds {high, low} product for mul and {remainder, quotient} for div.
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   drem;
    logic               dge;
    logic [2*WIDTH-1:0] acc_nxt;

    assign msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    assign rem_sh = {acc[2*WIDTH-1:WIDTH], acc[M]};
    assign dge    = rem_sh >= {1'b0, b_r};
    assign drem   = rem_sh[M:0] - b_r;

    always_comb begin
        if (op == 4'b1000)
            acc_nxt = {msum, acc[M:1]};
        else if (dge)
            acc_nxt = {drem, acc[M-1:0], 1'b1};
        else
            acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            overflowo <= 1'b0;
            carryo    <= 1'b0;
            erro      <= 1'b0;
            cnt       <= '0;
            op        <= '0;
            b_r       <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op       <= func;
                    b_r      <= b;
                    in_ready <= 1'b0;
                    if (is_iter) begin
                        state <= BUSY;
                        cnt   <= CW'(WIDTH);
                        acc   <= {{WIDTH{1'b0}}, a};
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out       <= s_out;
                        overflowo <= s_ovf;
                        carryo    <= s_car;
                        erro      <= s_err;
                    end
                end
                BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        erro      <= 1'b0;
                        if (op == 4'b1000) begin
                            out       <= acc_nxt[M:0];
                            overflowo <= |acc_nxt[2*WIDTH-1:WIDTH];
                            carryo    <= 1'b0;
                        end else begin
                            out       <= (op == 4'b1010) ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[M:0];
                            overflowo <= 1'b0;
                            carryo    <= (b_r == '0);
                        end
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu at WIDTH=8
module tb_seq_alu;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, out;
    logic [3:0] func;
    logic       overflowo, carryo, erro;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       e;
        logic       c;
        logic       v;
        logic [7:0] o;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] got_o;
    logic       got_v, got_c, got_e;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .func(func), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .overflowo(overflowo), .carryo(carryo), .erro(erro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y);
        exp_t r;
        int   sx, sy, s, p, amt;
        r   = '0;
        sx  = $signed(x);
        sy  = $signed(y);
        amt = int'(y[3:0]);
        case (f)
            4'd0: begin s = int'(x) + int'(y); r.o = s[7:0]; r.c = s > 255;
                        s = sx + sy; r.v = (s > 127) || (s < -128); end
            4'd1: begin r.o = x - y; r.c = x >= y;
                        s = sx - sy; r.v = (s > 127) || (s < -128); end
            4'd2: r.o = ~x;
            4'd3: r.o = x & y;
            4'd4: r.o = x | y;
            4'd5: r.o = x ^ y;
            4'd6: r.o = {7'b0, sx < sy};
            4'd7: r.o = {7'b0, x == y};
            4'd8: begin p = int'(x) * int'(y); r.o = p[7:0]; r.v = (p >> 8) != 0; end
            4'd9:  if (y == 8'd0) begin r.o = 8'hFF; r.c = 1'b1; end else r.o = x / y;
            4'd10: if (y == 8'd0) begin r.o = x;     r.c = 1'b1; end else r.o = x % y;
`ifdef SEQ_ALU_SHIFT_EN
            4'd11: begin r.o = (amt >= 8) ? 8'h00 : x << amt;
                         r.c = (amt == 0 || amt > 8) ? 1'b0 : x[8-amt]; end
            4'd12: begin r.o = (amt >= 8) ? 8'h00 : x >> amt;
                         r.c = (amt == 0 || amt > 8) ? 1'b0 : x[amt-1]; end
            4'd13: begin r.o = (amt >= 8) ? {8{x[7]}} : 8'($signed(x) >>> amt);
                         r.c = (amt == 0) ? 1'b0 : (amt > 8) ? x[7] : x[amt-1]; end
`endif
            default: r.e = 1'b1;
        endcase
        return r;
    endfunction

    // Every cycle a result is presented it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("out",       int'(out),       int'(exp_q[0].o));
                chk("overflowo", int'(overflowo), int'(exp_q[0].v));
                chk("carryo",    int'(carryo),    int'(exp_q[0].c));
                chk("erro",      int'(erro),      int'(exp_q[0].e));
                chk("in_ready_while_done", int'(in_ready), 0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y, input int lat);
        int  n;
        bit  seen;
        exp_q.push_back(model(f, x, y));
        chk("in_ready_idle", int'(in_ready), 1);
        a = x; b = y; func = f; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0; seen = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1; n = i;
                got_o = out; got_v = overflowo; got_c = carryo; got_e = erro;
            end
        end
        chk("latency", n, lat);
        if (out_ready) begin @(posedge clk); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; func = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out", int'(out), 0);
        rst_n = 1'b1;

        do_op(4'd0, 8'h7F, 8'h01, 1);
        chk("lit_add_out", int'(got_o), 8'h80); chk("lit_add_ovf", int'(got_v), 1); chk("lit_add_car", int'(got_c), 0);
        do_op(4'd1, 8'h00, 8'h01, 1);
        chk("lit_sub_out", int'(got_o), 8'hFF); chk("lit_sub_car", int'(got_c), 0); chk("lit_sub_ovf", int'(got_v), 0);
        do_op(4'd0, 8'hFF, 8'h01, 1);
        do_op(4'd1, 8'h80, 8'h01, 1);
        do_op(4'd2, 8'h3C, 8'h00, 1);
        do_op(4'd3, 8'hF0, 8'h3C, 1);
        do_op(4'd4, 8'hF0, 8'h0C, 1);
        do_op(4'd6, 8'h80, 8'h01, 1);
        chk("lit_slt1", int'(got_o), 1);
        do_op(4'd7, 8'h5A, 8'h5A, 1);
        chk("lit_eq", int'(got_o), 1);
        do_op(4'd6, 8'h01, 8'h80, 1);
        chk("lit_slt0", int'(got_o), 0);
        do_op(4'd7, 8'h5A, 8'h5B, 1);

        do_op(4'd8, 8'h10, 8'h20, 9);
        chk("lit_mul1_out", int'(got_o), 8'h00); chk("lit_mul1_ovf", int'(got_v), 1);
        do_op(4'd8, 8'h0C, 8'h0B, 9);
        chk("lit_mul2_out", int'(got_o), 8'h84); chk("lit_mul2_ovf", int'(got_v), 0);
        do_op(4'd8, 8'hFF, 8'hFF, 9);
        do_op(4'd9, 8'hC8, 8'h07, 9);
        chk("lit_divu", int'(got_o), 8'h1C);
        do_op(4'd10, 8'hC8, 8'h07, 9);
        chk("lit_remu", int'(got_o), 8'h04);
        do_op(4'd9, 8'hFF, 8'h01, 9);
        do_op(4'd10, 8'h07, 8'hC8, 9);
        do_op(4'd9, 8'h33, 8'h00, 9);
        chk("lit_div0_out", int'(got_o), 8'hFF); chk("lit_div0_car", int'(got_c), 1);
        do_op(4'd10, 8'h33, 8'h00, 9);
        chk("lit_rem0_out", int'(got_o), 8'h33); chk("lit_rem0_car", int'(got_c), 1);

        // Reset while the multiplier is iterating.
        a = 8'h0F; b = 8'h0F; func = 4'd8; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out", int'(out), 0);
        chk("midrst_flags", int'({overflowo, carryo, erro}), 0);
        rst_n = 1'b1;
        do_op(4'd8, 8'h0F, 8'h0F, 9);

        do_op(4'd15, 8'h12, 8'h34, 1);
        chk("lit_illegal_err", int'(got_e), 1); chk("lit_illegal_out", int'(got_o), 0);

        // Backpressure: result must hold while a competing request is ignored.
        out_ready = 1'b0;
        do_op(4'd5, 8'hA5, 8'h0F, 1);
        for (int i = 0; i < 5; i++) begin
            a = 8'h11; b = 8'h22; func = 4'd0; in_valid = 1'b1;
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_ignored_req", int'(out_valid), 0);
        @(posedge clk); #1;

`ifdef SEQ_ALU_SHIFT_EN
        do_op(4'd13, 8'h90, 8'h02, 1);
        chk("lit_sar_out", int'(got_o), 8'hE4); chk("lit_sar_car", int'(got_c), 0);
        do_op(4'd11, 8'h81, 8'h01, 1);
        do_op(4'd12, 8'h81, 8'h09, 1);
        do_op(4'd13, 8'h80, 8'h0C, 1);
        do_op(4'd12, 8'hB6, 8'h00, 1);
`else
        do_op(4'd11, 8'h90, 8'h02, 1);
        chk("lit_shl_illegal", int'(got_e), 1);
        do_op(4'd13, 8'h90, 8'h02, 1);
`endif

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
